// File: rtl/cnt_seq_ctrl_if.sv
// cnt_seq_ctrl_if: command handshake carrying {start, end, mode} into the counter sequencer.
interface cnt_seq_ctrl_if #(
    parameter int W = 8
);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_start;
    logic [W-1:0] cmd_end;
    logic         cmd_mode;

    modport master (
        output cmd_valid,
        output cmd_start,
        output cmd_end,
        output cmd_mode,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_start,
        input  cmd_end,
        input  cmd_mode,
        output cmd_ready
    );
endinterface

// File: rtl/cnt_seq_ctrl.sv
// cnt_seq_ctrl: command-driven sequencer for an 8-bit loadable up-counter.
// Optional en prescaler enabled by defining CNT_SEQ_PRESCALE_EN.
module cnt_seq_ctrl #(
    parameter int W       = 8,
    parameter int PRESC_W = 4
) (
    input  logic               clk,
    input  logic               arst_n,
    cnt_seq_ctrl_if.slave      cmd,
    input  logic               i_abort,
`ifdef CNT_SEQ_PRESCALE_EN
    input  logic [PRESC_W-1:0] i_presc_div,
`endif
    input  logic [W-1:0]       i_cnt_q,
    output logic               o_ctr_load,
    output logic [W-1:0]       o_ctr_load_val,
    output logic               o_ctr_en,
    output logic               o_ctr_oe,
    output logic               o_busy,
    output logic               o_done
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_start;
    logic [W-1:0] r_end;
    logic         r_mode;
    logic         r_done;
    logic         r_oe_keep;
    logic         w_accept;
    logic         w_term;
    logic         w_run_term;
    logic         w_tick;

    if (PRESC_W < 1) begin : g_bad_presc_w
        $error("PRESC_W must be at least 1");
    end

    assign w_accept   = (r_state == IDLE) && cmd.cmd_valid;
    assign w_term     = (i_cnt_q == r_end);
    assign w_run_term = (r_state == RUN) && !i_abort && w_term;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = cmd.cmd_valid ? LOAD : IDLE;
            LOAD:    w_next = i_abort ? IDLE : RUN;
            RUN:     w_next = i_abort ? IDLE : w_term ? (r_mode ? LOAD : IDLE) : RUN;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd.cmd_ready  = (r_state == IDLE);
        o_busy         = (r_state != IDLE);
        o_ctr_load     = (r_state == LOAD) && !i_abort;
        o_ctr_en       = (r_state == RUN) && !i_abort && !w_term && w_tick;
        o_ctr_oe       = (r_state != IDLE) || r_oe_keep;
        o_ctr_load_val = r_start;
        o_done         = r_done;
    end

    // oe_keep holds the finished one-shot's result visible; any abort or new command drops it
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_start   <= '0;
            r_end     <= '0;
            r_mode    <= 1'b0;
            r_done    <= 1'b0;
            r_oe_keep <= 1'b0;
        end else begin
            if (w_accept) begin
                r_start <= cmd.cmd_start;
                r_end   <= cmd.cmd_end;
                r_mode  <= cmd.cmd_mode;
            end
            r_done    <= w_run_term;
            r_oe_keep <= (w_accept || i_abort) ? 1'b0 : (w_run_term && !r_mode) ? 1'b1 : r_oe_keep;
        end
    end

`ifdef CNT_SEQ_PRESCALE_EN
    logic [PRESC_W-1:0] r_presc_div;
    logic [PRESC_W-1:0] r_presc_cnt;

    assign w_tick = (r_presc_cnt == r_presc_div);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_presc_div <= '0;
            r_presc_cnt <= '0;
        end else begin
            if (w_accept) r_presc_div <= i_presc_div;
            if (r_state == LOAD) r_presc_cnt <= '0;
            else if (r_state == RUN) r_presc_cnt <= w_tick ? '0 : r_presc_cnt + 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif
endmodule
